uart_tx: RTL and testbench

Serial UART transmitter that pairs with the team's `uart_rx`. It sits directly upstream of it on the serial line, on the far side of the link or in loopback. It shares the receiver's clock assumption and its baud-select encoding: 50 MHz `clk_i`, 16 ticks per bit, identical divider constants. It accepts one byte per start strobe, serialises it LSB-first as 8N1 (optionally with a parity bit), and reports busy and done.

---
 rtl/uart_tx_if.sv | 28 ++
 rtl/uart_tx.sv | 164 ++++++++++++++++
 tb/tb_uart_tx.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_if.sv
// Byte-in / serial-out handshake for the UART transmitter.
// The master drives the byte, the start strobe and the baud code; the slave returns the line and status.
interface uart_tx_if;
    logic [7:0] tx_data_i;
    logic       tx_start_i;
    logic [2:0] buad_set_i;
    logic       uart_tx_o;
    logic       tx_busy_o;
    logic       tx_done_o;

    modport master (
        output tx_data_i,
        output tx_start_i,
        output buad_set_i,
        input  uart_tx_o,
        input  tx_busy_o,
        input  tx_done_o
    );

    modport slave (
        input  tx_data_i,
        input  tx_start_i,
        input  buad_set_i,
        output uart_tx_o,
        output tx_busy_o,
        output tx_done_o
    );
endinterface

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with optional parity, 16 ticks per bit from a 50 MHz clock.
// Divider constants and baud-code mapping are shared with uart_rx so both ends use the same N.
module uart_tx #(
    parameter bit PARITY_EN  = 1'b0,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic      clk_i,
    input  logic      rst_n,
    uart_tx_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t     state_q, state_d;
    logic [8:0] div_q, div_d;
    logic [8:0] tick_cnt_q, tick_cnt_d;
    logic [3:0] sub_cnt_q, sub_cnt_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       parity_q, parity_d;
    logic       line_q, line_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic [8:0] div_sel;
    logic       tick;
    logic       bit_end;

    function automatic logic [8:0] div_for(input logic [2:0] code);
        case (code)
            3'd1:    return 9'd325;
            3'd2:    return 9'd162;
            3'd3:    return 9'd81;
            3'd4:    return 9'd54;
            default: return 9'd27;
        endcase
    endfunction

    always_comb begin
        div_sel    = div_for(bus.buad_set_i);
        tick       = (tick_cnt_q == 9'd0);
        bit_end    = tick && (sub_cnt_q == 4'd15);

        state_d    = state_q;
        div_d      = div_q;
        tick_cnt_d = tick_cnt_q;
        sub_cnt_d  = sub_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        line_d     = line_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        // One tick every N clocks while a frame is running; a bit ends on the 16th tick.
        if (state_q != S_IDLE) begin
            if (tick) begin
                tick_cnt_d = div_q - 9'd1;
                sub_cnt_d  = sub_cnt_q + 4'd1;
            end else begin
                tick_cnt_d = tick_cnt_q - 9'd1;
            end
        end

        case (state_q)
            S_IDLE: begin
                tick_cnt_d = div_q - 9'd1;
                sub_cnt_d  = 4'd0;
                bit_cnt_d  = 3'd0;
                line_d     = 1'b1;
                busy_d     = 1'b0;
                if (bus.tx_start_i) begin
                    div_d      = div_sel;
                    tick_cnt_d = div_sel - 9'd1;
                    shift_d    = bus.tx_data_i;
                    parity_d   = PARITY_ODD ? ~(^bus.tx_data_i) : ^bus.tx_data_i;
                    line_d     = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    line_d  = shift_q[0];
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_cnt_q == 3'd7) begin
                        bit_cnt_d = 3'd0;
                        if (PARITY_EN) begin
                            line_d  = parity_q;
                            state_d = S_PARITY;
                        end else begin
                            line_d  = 1'b1;
                            state_d = S_STOP;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                        line_d    = shift_q[1];
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    line_d  = 1'b1;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    line_d  = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                line_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            div_q      <= 9'd27;
            tick_cnt_q <= 9'd26;
            sub_cnt_q  <= 4'd0;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'h00;
            parity_q   <= 1'b0;
            line_q     <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            tick_cnt_q <= tick_cnt_d;
            sub_cnt_q  <= sub_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            line_q     <= line_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.uart_tx_o = line_q;
    assign bus.tx_busy_o = busy_q;
    assign bus.tx_done_o = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a frame monitor on the no-parity instance checks every frame against a queue
// of expected {byte, N, start edge}; two parity instances run the 9600-baud parity frame in parallel.
module tb_uart_tx;

    logic clk = 1'b0;
    logic rst_n;
    logic rst_p_n;
    int   cyc = 0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_if bm();
    uart_tx_if bpe();
    uart_tx_if bpo();

    uart_tx #(.PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u_main (.clk_i(clk), .rst_n(rst_n),   .bus(bm));
    uart_tx #(.PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_pe   (.clk_i(clk), .rst_n(rst_p_n), .bus(bpe));
    uart_tx #(.PARITY_EN(1'b1), .PARITY_ODD(1'b1)) u_po   (.clk_i(clk), .rst_n(rst_p_n), .bus(bpo));

    typedef struct {
        logic [7:0] data;
        int         n;
        int         t0;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        logic [2:0] code;
        int         n;
    } vec_t;

    exp_t sb[$];
    bit   mon_act   = 1'b0;
    int   frames_done = 0;
    int   done_cnt  = 0;
    bit   par_done  = 1'b0;

    task automatic check_eq(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, req, cyc);
        end
    endtask

    // Frame monitor for the main instance, sampled on the falling edge.
    initial begin
        exp_t cur;
        int   mon_p;
        int   bit_len;
        int   k;
        int   ph;
        int   exp_bit;
        mon_p = 0;
        cur   = '{data: 8'h00, n: 27, t0: 0};
        forever begin
            @(negedge clk);
            if (bm.tx_done_o) done_cnt++;
            if (!rst_n) begin
                check_eq("rst_line", int'(bm.uart_tx_o), 1);
                check_eq("rst_busy", int'(bm.tx_busy_o), 0);
                check_eq("rst_done", int'(bm.tx_done_o), 0);
                if (mon_act) begin
                    mon_act = 1'b0;
                    void'(sb.pop_front());
                end
            end else begin
                if (!mon_act) begin
                    check_eq("idle_done", int'(bm.tx_done_o), 0);
                    if (bm.uart_tx_o == 1'b0) begin
                        check_eq("frame_expected", int'(sb.size() > 0), 1);
                        if (sb.size() > 0) begin
                            cur     = sb[0];
                            check_eq("start_edge", cyc, cur.t0);
                            mon_act = 1'b1;
                            mon_p   = 0;
                        end
                    end else begin
                        check_eq("idle_busy", int'(bm.tx_busy_o), 0);
                    end
                end
                if (mon_act) begin
                    bit_len = 16 * cur.n;
                    if (mon_p < bit_len * 10) begin
                        k  = mon_p / bit_len;
                        ph = mon_p % bit_len;
                        check_eq("done_early", int'(bm.tx_done_o), 0);
                        if (ph == 0 || ph == bit_len / 2 || ph == bit_len - 1) begin
                            if (k == 0)      exp_bit = 0;
                            else if (k == 9) exp_bit = 1;
                            else             exp_bit = int'(cur.data[k-1]);
                            check_eq($sformatf("line_bit%0d_ph%0d", k, ph), int'(bm.uart_tx_o), exp_bit);
                            check_eq("busy_frame", int'(bm.tx_busy_o), 1);
                        end
                        mon_p++;
                    end else begin
                        check_eq("done_pulse", int'(bm.tx_done_o), 1);
                        check_eq("busy_end", int'(bm.tx_busy_o), 0);
                        check_eq("line_end", int'(bm.uart_tx_o), 1);
                        void'(sb.pop_front());
                        mon_act = 1'b0;
                        frames_done++;
                        $display("frame data=%02h N=%0d t0=%0d done at cycle %0d", cur.data, cur.n, cur.t0, cyc);
                    end
                end
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic [2:0] code, input int n);
        int t;
        @(posedge clk);
        #1;
        bm.tx_data_i  = d;
        bm.buad_set_i = code;
        bm.tx_start_i = 1'b1;
        t = cyc + 1;
        sb.push_back('{data: d, n: n, t0: t});
        @(posedge clk);
        #1;
        bm.tx_start_i = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        for (int i = 0; i < limit; i++) begin
            if (sb.size() == 0 && !mon_act) break;
            @(posedge clk);
        end
        #1;
        check_eq("frames_pending", sb.size(), 0);
    endtask

    // Parity frames at 9600 on the even and odd instances.
    initial begin
        logic [10:0] fe;
        logic [10:0] fo;
        int          bl;
        int          k;
        int          ph;
        fe = {1'b1, 1'b0, 8'hA3, 1'b0};
        fo = {1'b1, 1'b1, 8'hA3, 1'b0};
        bl = 16 * 325;
        bpe.tx_data_i = 8'h00; bpe.tx_start_i = 1'b0; bpe.buad_set_i = 3'd0;
        bpo.tx_data_i = 8'h00; bpo.tx_start_i = 1'b0; bpo.buad_set_i = 3'd0;
        rst_p_n = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("pe_rst_line", int'(bpe.uart_tx_o), 1);
        check_eq("po_rst_busy", int'(bpo.tx_busy_o), 0);
        check_eq("pe_rst_done", int'(bpe.tx_done_o), 0);
        @(posedge clk);
        #1 rst_p_n = 1'b1;
        @(posedge clk);
        #1;
        bpe.tx_data_i = 8'hA3; bpe.buad_set_i = 3'd1; bpe.tx_start_i = 1'b1;
        bpo.tx_data_i = 8'hA3; bpo.buad_set_i = 3'd1; bpo.tx_start_i = 1'b1;
        @(posedge clk);
        #1;
        bpe.tx_start_i = 1'b0; bpe.tx_data_i = 8'h5C; bpe.buad_set_i = 3'd0;
        bpo.tx_start_i = 1'b0; bpo.tx_data_i = 8'h5C; bpo.buad_set_i = 3'd0;
        for (int p = 0; p <= bl * 11; p++) begin
            @(negedge clk);
            if (p < bl * 11) begin
                k  = p / bl;
                ph = p % bl;
                check_eq("pe_done_early", int'(bpe.tx_done_o), 0);
                check_eq("po_done_early", int'(bpo.tx_done_o), 0);
                if (ph == 0 || ph == bl / 2 || ph == bl - 1) begin
                    check_eq($sformatf("pe_bit%0d_ph%0d", k, ph), int'(bpe.uart_tx_o), int'(fe[k]));
                    check_eq($sformatf("po_bit%0d_ph%0d", k, ph), int'(bpo.uart_tx_o), int'(fo[k]));
                    check_eq("pe_busy", int'(bpe.tx_busy_o), 1);
                end
            end else begin
                check_eq("pe_done_57200", int'(bpe.tx_done_o), 1);
                check_eq("po_done_57200", int'(bpo.tx_done_o), 1);
                check_eq("po_busy_end", int'(bpo.tx_busy_o), 0);
            end
        end
        $display("parity frames even/odd data=a3 checked through cycle %0d", cyc);
        par_done = 1'b1;
    end

    initial begin
        vec_t       vecs[4];
        logic [7:0] bb[3];
        int         f0;
        int         d0;
        int         t;

        vecs[0] = '{data: 8'h55, code: 3'd0, n: 27};
        vecs[1] = '{data: 8'hC3, code: 3'd7, n: 27};
        vecs[2] = '{data: 8'h81, code: 3'd4, n: 54};
        vecs[3] = '{data: 8'h7E, code: 3'd3, n: 81};
        bb[0] = 8'hA5; bb[1] = 8'h0F; bb[2] = 8'hE7;

        bm.tx_data_i  = 8'h00;
        bm.tx_start_i = 1'b0;
        bm.buad_set_i = 3'd0;
        rst_n = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("post_rst_line", int'(bm.uart_tx_o), 1);
        check_eq("post_rst_busy", int'(bm.tx_busy_o), 0);

        for (int i = 0; i < 4; i++) begin
            send(vecs[i].data, vecs[i].code, vecs[i].n);
            wait_idle(160 * vecs[i].n + 100);
        end

        // Strobe with 0xFF at edge 100 of a 0x00 frame must be ignored.
        f0 = frames_done;
        d0 = done_cnt;
        send(8'h00, 3'd0, 27);
        repeat (99) @(posedge clk);
        #1;
        bm.tx_data_i  = 8'hFF;
        bm.tx_start_i = 1'b1;
        @(posedge clk);
        #1;
        bm.tx_start_i = 1'b0;
        bm.tx_data_i  = 8'h00;
        wait_idle(4500);
        repeat (500) @(posedge clk);
        #1;
        check_eq("busy_strobe_frames", frames_done - f0, 1);
        check_eq("busy_strobe_dones", done_cnt - d0, 1);
        check_eq("busy_strobe_idle", int'(bm.tx_busy_o), 0);

        // Baud code change at edge 2000 must not stretch the running frame.
        send(8'h3C, 3'd4, 54);
        repeat (1999) @(posedge clk);
        #1 bm.buad_set_i = 3'd1;
        wait_idle(9000);

        // Reset during data bit 3 aborts the frame without a done pulse.
        f0 = frames_done;
        d0 = done_cnt;
        send(8'h5A, 3'd0, 27);
        repeat (1900) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_eq("async_rst_line", int'(bm.uart_tx_o), 1);
        check_eq("async_rst_busy", int'(bm.tx_busy_o), 0);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("abort_queue", sb.size(), 0);
        check_eq("abort_frames", frames_done - f0, 0);
        check_eq("abort_dones", done_cnt - d0, 0);
        send(8'h96, 3'd0, 27);
        wait_idle(4500);

        // Start held high: back-to-back frames every 16*N*10+1 clocks.
        @(posedge clk);
        #1;
        bm.tx_data_i  = bb[0];
        bm.buad_set_i = 3'd5;
        bm.tx_start_i = 1'b1;
        t = cyc + 1;
        sb.push_back('{data: bb[0], n: 27, t0: t});
        for (int i = 1; i < 3; i++) begin
            @(posedge clk);
            #1;
            bm.tx_data_i = bb[i];
            t = t + 4321;
            sb.push_back('{data: bb[i], n: 27, t0: t});
            repeat (4320) @(posedge clk);
        end
        @(posedge clk);
        #1 bm.tx_start_i = 1'b0;
        wait_idle(4500);

        for (int i = 0; i < 70000; i++) begin
            if (par_done) break;
            @(posedge clk);
        end
        check_eq("parity_finished", int'(par_done), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
